// File: rtl/termo_pkg.sv
// Shared types and constants for the guessing-game round controller.
package termo_pkg;

    typedef enum logic [2:0] {
        ENTRY   = 3'd0,
        SUBMIT  = 3'd1,
        SCORING = 3'd2,
        CHECK   = 3'd3,
        WON     = 3'd4,
        LOST    = 3'd5
    } state_t;

    localparam logic [1:0] HINT_CORRECT = 2'b10;
    localparam logic [1:0] HINT_PRESENT = 2'b01;
    localparam logic [1:0] HINT_ABSENT  = 2'b00;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    function automatic logic all_correct(input logic [1:0] h2,
                                         input logic [1:0] h1,
                                         input logic [1:0] h0);
        return (h2 == HINT_CORRECT) && (h1 == HINT_CORRECT) && (h0 == HINT_CORRECT);
    endfunction

endpackage

// File: rtl/guess_buffer.sv
// Three-digit guess storage with push/pop/clear; d2 is filled first.
module guess_buffer
    import termo_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       push,
    input  logic [3:0] push_digit,
    input  logic       pop,
    input  logic       clear,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic [1:0] count
);

    // clear wins over pop, pop over push; out-of-range pushes are dropped here
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            d2    <= 4'd0;
            d1    <= 4'd0;
            d0    <= 4'd0;
            count <= 2'd0;
        end else if (clear) begin
            d2    <= 4'd0;
            d1    <= 4'd0;
            d0    <= 4'd0;
            count <= 2'd0;
        end else if (pop && (count != 2'd0)) begin
            case (count)
                2'd1:    d2 <= 4'd0;
                2'd2:    d1 <= 4'd0;
                2'd3:    d0 <= 4'd0;
                default: ;
            endcase
            count <= count - 2'd1;
        end else if (push && (count != 2'd3) && (push_digit <= DIGIT_MAX)) begin
            case (count)
                2'd0:    d2 <= push_digit;
                2'd1:    d1 <= push_digit;
                2'd2:    d0 <= push_digit;
                default: ;
            endcase
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/round_controller.sv
// Round controller: digit entry, submit/score handshake, win/lose tracking.
// Optional idle-entry forfeit timer enabled by defining ROUND_TIMEOUT_EN.
module round_controller
    import termo_pkg::*;
#(
    parameter int MAX_ATTEMPTS   = 6,
    parameter int SCORE_LATENCY  = 3,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       KEY_VALID,
    input  logic [3:0] KEY_DIGIT,
    input  logic       KEY_ENTER,
    input  logic       KEY_BACK,
    input  logic [1:0] H2,
    input  logic [1:0] H1,
    input  logic [1:0] H0,
    output logic [3:0] GUESS_D2,
    output logic [3:0] GUESS_D1,
    output logic [3:0] GUESS_D0,
    output logic [1:0] DIGIT_COUNT,
    output logic [2:0] ATTEMPT,
    output logic       ENTER,
    output logic       NEW_GAME,
    output logic       BUSY,
    output logic       WIN,
    output logic       LOSE
);

    localparam int             LAT_W    = (SCORE_LATENCY > 1) ? $clog2(SCORE_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(SCORE_LATENCY - 1);
    localparam logic [2:0]     ATT_MAX  = 3'(MAX_ATTEMPTS);

    state_t           state;
    state_t           state_nxt;
    logic [LAT_W-1:0] lat_cnt;
    logic             hit;
    logic             last_try;
    logic             miss;
    logic             start_game;
    logic             timeout_hit;
    logic             buf_push;
    logic             buf_pop;
    logic             buf_clear;

    assign hit      = all_correct(H2, H1, H0);
    assign last_try = ((ATTEMPT + 3'd1) == ATT_MAX);

`ifdef ROUND_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic             key_any;
    logic [TMO_W-1:0] tmo_cnt;

    assign key_any     = KEY_VALID | KEY_ENTER | KEY_BACK;
    assign timeout_hit = (state == ENTRY) && !key_any &&
                         (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Any key, even one that is ignored, restarts the idle window
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmo_cnt <= '0;
        end else if ((state != ENTRY) || key_any || timeout_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ENTRY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ENTRY: begin
                if (KEY_ENTER && (DIGIT_COUNT == 2'd3)) begin
                    state_nxt = SUBMIT;
                end else if (timeout_hit) begin
                    state_nxt = last_try ? LOST : ENTRY;
                end
            end
            SUBMIT:  state_nxt = SCORING;
            SCORING: if (lat_cnt == LAT_LAST) state_nxt = CHECK;
            CHECK: begin
                if (hit) begin
                    state_nxt = WON;
                end else begin
                    state_nxt = last_try ? LOST : ENTRY;
                end
            end
            WON, LOST: if (KEY_ENTER) state_nxt = ENTRY;
            default: state_nxt = ENTRY;
        endcase
    end

    // Key priority in ENTRY: ENTER, then BACK, then digit
    always_comb begin
        buf_push   = 1'b0;
        buf_pop    = 1'b0;
        buf_clear  = 1'b0;
        miss       = 1'b0;
        start_game = 1'b0;
        BUSY       = 1'b0;
        WIN        = 1'b0;
        LOSE       = 1'b0;
        case (state)
            ENTRY: begin
                if (KEY_ENTER) begin
                    buf_push = 1'b0;
                end else if (KEY_BACK) begin
                    buf_pop = 1'b1;
                end else if (KEY_VALID) begin
                    buf_push = 1'b1;
                end
                miss      = timeout_hit;
                buf_clear = timeout_hit && !last_try;
            end
            SUBMIT, SCORING: BUSY = 1'b1;
            CHECK: begin
                BUSY      = 1'b1;
                miss      = !hit;
                buf_clear = !hit && !last_try;
            end
            WON: begin
                WIN        = 1'b1;
                start_game = KEY_ENTER;
                buf_clear  = KEY_ENTER;
            end
            LOST: begin
                LOSE       = 1'b1;
                start_game = KEY_ENTER;
                buf_clear  = KEY_ENTER;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ENTER    <= 1'b0;
            NEW_GAME <= 1'b0;
            ATTEMPT  <= 3'd0;
            lat_cnt  <= '0;
        end else begin
            ENTER    <= (state_nxt == SUBMIT);
            NEW_GAME <= start_game;
            if (start_game) begin
                ATTEMPT <= 3'd0;
            end else if (miss && (ATTEMPT != ATT_MAX)) begin
                ATTEMPT <= ATTEMPT + 3'd1;
            end
            lat_cnt <= (state == SCORING) ? lat_cnt + 1'b1 : '0;
        end
    end

    guess_buffer u_guess_buffer (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .push       (buf_push),
        .push_digit (KEY_DIGIT),
        .pop        (buf_pop),
        .clear      (buf_clear),
        .d2         (GUESS_D2),
        .d1         (GUESS_D1),
        .d0         (GUESS_D0),
        .count      (DIGIT_COUNT)
    );

endmodule
